// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expire flags the TIMEOUT-th consecutive enabled cycle.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Combinational so the abort lands on the same edge as the T-th low-ready cycle.
    assign expire = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns single write/read requests into SETUP/ACCESS bus sequences.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              TRANSFER,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] apb_write_address,
    input  logic [DATA_W-1:0] apb_write_data,
    input  logic [ADDR_W-1:0] apb_read_address,
    output logic              busy,
    output logic              psel1,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              pready1,
    input  logic              PSLVERR,
    output logic [DATA_W-1:0] apb_read_out,
    output logic              done,
    output logic              err,
    output logic              timeout
);

    apb_state_e        state_q, state_d;
    apb_req_t          req_q, req_d;
    logic              psel_d, penable_d, done_d, err_d, timeout_d;
    logic [DATA_W-1:0] rdata_d;
    logic              accept, wait_expire, timer_clear, timer_en;

    assign accept      = TRANSFER && (write || read);
    assign timer_clear = (state_q == SETUP);
    assign timer_en    = (state_q == ACCESS) && !pready1;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (wait_expire)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready1 || wait_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; bus strobes follow the next state.
    always_comb begin
        req_d     = req_q;
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
        done_d    = 1'b0;
        err_d     = err;
        timeout_d = timeout;
        rdata_d   = apb_read_out;
        if ((state_q == IDLE) && accept) begin
            req_d.write = write;
            req_d.addr  = write ? APB_ADDR_W'(apb_write_address) : APB_ADDR_W'(apb_read_address);
            req_d.wdata = APB_DATA_W'(apb_write_data);
        end
        if (state_q == ACCESS) begin
            if (pready1) begin
                done_d    = 1'b1;
                err_d     = PSLVERR;
                timeout_d = 1'b0;
                if (!req_q.write && !PSLVERR) begin
                    rdata_d = PRDATA;
                end
            end else if (wait_expire) begin
                done_d    = 1'b1;
                err_d     = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            req_q        <= '0;
            psel1        <= 1'b0;
            PENABLE      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            apb_read_out <= '0;
        end else begin
            req_q        <= req_d;
            psel1        <= psel_d;
            PENABLE      <= penable_d;
            done         <= done_d;
            err          <= err_d;
            timeout      <= timeout_d;
            apb_read_out <= rdata_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign PWRITE = req_q.write;
    assign PADDR  = ADDR_W'(req_q.addr);
    assign PWDATA = DATA_W'(req_q.wdata);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized transaction-level bench for apb_master_bridge.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        TRANSFER, write, read;
    logic [31:0] apb_write_address, apb_write_data, apb_read_address;
    logic        busy, psel1, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA, apb_read_out;
    logic        pready1, PSLVERR, done, err, timeout;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rd;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .TRANSFER          (TRANSFER),
        .write             (write),
        .read              (read),
        .apb_write_address (apb_write_address),
        .apb_write_data    (apb_write_data),
        .apb_read_address  (apb_read_address),
        .busy              (busy),
        .psel1             (psel1),
        .PENABLE           (PENABLE),
        .PWRITE            (PWRITE),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .PRDATA            (PRDATA),
        .pready1           (pready1),
        .PSLVERR           (PSLVERR),
        .apb_read_out      (apb_read_out),
        .done              (done),
        .err               (err),
        .timeout           (timeout)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_req();
        TRANSFER          = 1'b1;
        write             = 1'($urandom);
        read              = 1'($urandom);
        apb_write_address = $urandom;
        apb_read_address  = $urandom;
        apb_write_data    = $urandom;
    endtask

    // One transfer: waits = low-ready ACCESS cycles before ready; noise = requests while busy.
    task automatic run_xfer(input logic wr, input logic rd, input logic [31:0] waddr,
                            input logic [31:0] raddr, input logic [31:0] wdata, input int waits,
                            input logic slverr, input logic [31:0] rdata, input logic noise);
        logic [31:0] exp_addr;
        logic        exp_to, exp_err;
        int          exp_acc, acc, cyc;
        bit          seen;
        exp_addr = wr ? waddr : raddr;
        exp_to   = (waits >= TO);
        exp_acc  = exp_to ? TO : waits + 1;
        exp_err  = exp_to | slverr;

        @(negedge PCLK);
        TRANSFER = 1'b1; write = wr; read = rd;
        apb_write_address = waddr; apb_read_address = raddr; apb_write_data = wdata;
        pready1 = 1'b0;
        @(negedge PCLK);
        cyc = 1; acc = 0; seen = 0;
        if (noise) scramble_req(); else TRANSFER = 1'b0;
        check("setup_psel", 64'(psel1), 64'(1));
        check("setup_penable", 64'(PENABLE), 64'(0));
        check("setup_busy", 64'(busy), 64'(1));
        check("setup_pwrite", 64'(PWRITE), 64'(wr));
        check("setup_paddr", 64'(PADDR), 64'(exp_addr));

        while (!seen && cyc < 64) begin
            @(negedge PCLK);
            cyc++;
            if (done) begin
                seen = 1;
                TRANSFER = 1'b0; pready1 = 1'b0;
                if (!wr && !exp_err) model_rd = rdata;
                check("done_cycle", 64'(cyc), 64'(2 + exp_acc));
                check("done_err", 64'(err), 64'(exp_err));
                check("done_timeout", 64'(timeout), 64'(exp_to));
                check("read_out", 64'(apb_read_out), 64'(model_rd));
                check("done_busy", 64'(busy), 64'(0));
                check("done_psel", 64'(psel1), 64'(0));
            end else begin
                acc++;
                check("acc_psel", 64'(psel1), 64'(1));
                check("acc_penable", 64'(PENABLE), 64'(1));
                check("acc_pwrite", 64'(PWRITE), 64'(wr));
                check("acc_paddr", 64'(PADDR), 64'(exp_addr));
                check("acc_pwdata", 64'(PWDATA), 64'(wdata));
                pready1 = (acc == waits + 1);
                PSLVERR = pready1 ? slverr : 1'($urandom);
                PRDATA  = pready1 ? rdata : $urandom;
                if (noise) scramble_req();
            end
        end
        if (!seen) check("done_seen", 64'(0), 64'(1));
        @(negedge PCLK);
        check("done_pulse", 64'(done), 64'(0));
        check("idle_psel", 64'(psel1), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        PRESET = 1'b1; TRANSFER = 1'b0; write = 1'b0; read = 1'b0;
        apb_write_address = '0; apb_write_data = '0; apb_read_address = '0;
        PRDATA = '0; pready1 = 1'b0; PSLVERR = 1'b0;
        model_rd = '0;
        repeat (2) @(negedge PCLK);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_psel", 64'(psel1), 64'(0));
        check("rst_penable", 64'(PENABLE), 64'(0));
        check("rst_pwrite", 64'(PWRITE), 64'(0));
        check("rst_paddr", 64'(PADDR), 64'(0));
        check("rst_pwdata", 64'(PWDATA), 64'(0));
        check("rst_read_out", 64'(apb_read_out), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        PRESET = 1'b0;

        run_xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
        run_xfer(1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
        run_xfer(1'b0, 1'b1, 32'h0, 32'h24, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
        run_xfer(1'b0, 1'b1, 32'h0, 32'h28, 32'h0, 40, 1'b0, 32'h5555_AAAA, 1'b0);
        run_xfer(1'b0, 1'b1, 32'h0, 32'h2C, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
        run_xfer(1'b0, 1'b1, 32'h0, 32'h30, 32'h0, TO, 1'b0, 32'h7777_7777, 1'b0);
        run_xfer(1'b1, 1'b1, 32'h40, 32'h44, 32'h1111_2222, 0, 1'b0, 32'h9999_9999, 1'b1);

        // Reset during ACCESS drops the bus at once and yields no done.
        @(negedge PCLK);
        TRANSFER = 1'b1; write = 1'b0; read = 1'b1; apb_read_address = 32'h50; pready1 = 1'b0;
        @(negedge PCLK);
        TRANSFER = 1'b0;
        @(negedge PCLK);
        check("pre_rst_access", 64'({psel1, PENABLE}), 64'(2'b11));
        #2 PRESET = 1'b1;
        #1;
        check("arst_psel", 64'(psel1), 64'(0));
        check("arst_penable", 64'(PENABLE), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_read_out", 64'(apb_read_out), 64'(0));
        model_rd = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("post_rst_done", 64'(done), 64'(0));
            check("post_rst_psel", 64'(psel1), 64'(0));
        end
        run_xfer(1'b0, 1'b1, 32'h0, 32'h60, 32'h0, 2, 1'b0, 32'hA5A5_5A5A, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic wr, rd;
            int   waits;
            wr    = 1'($urandom);
            rd    = wr ? 1'($urandom) : 1'b1;
            waits = (($urandom % 8) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                          : int'($urandom_range(0, 4));
            run_xfer(wr, rd, $urandom, $urandom, $urandom, waits,
                     1'(($urandom % 4) == 0), $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
